// File: rtl/cymometer_equal_precision.sv
`default_nettype none
// ============================================================================
// Module   : cymometer_equal_precision
// Brief    : Equal-precision (reciprocal) frequency meter. The gate opens and
//            closes on rising edges of clk_fx, counts fx rises (Nx) and sys_clk
//            cycles (Ns), then computes CLK_FREQ_HZ*Nx/Ns with a restoring
//            divider. Adds timeout, saturation, valid strobe and run modes.
// Revision : 1.0 - initial release
// ============================================================================
module cymometer_equal_precision #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int GATE_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 1_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 32,
  parameter int FRE_W          = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int CONTINUOUS     = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_fx,
  input  logic             start,
  output logic [FRE_W-1:0] fre,
  output logic [CNT_W-1:0] nx,
  output logic [CNT_W-1:0] ns,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic             sat
);

  localparam int c_NUM_W  = CNT_W + 32;
  localparam int c_DCNT_W = $clog2(c_NUM_W);
  localparam logic [CNT_W-1:0]    c_GAP     = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]    c_GATE    = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0]    c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_NUM_W-1:0]  c_FREQ    = c_NUM_W'(CLK_FREQ_HZ);
  localparam logic [c_DCNT_W-1:0] c_DLAST   = c_DCNT_W'(c_NUM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_OPEN  = 3'd2,
    S_CLOSE = 3'd3,
    S_DIV   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fx_dly_q;
  logic                   fx_rise;
  logic [CNT_W-1:0]       tmr_q, tmr_d, tmr_inc;
  logic [CNT_W-1:0]       nx_q, nx_d, ns_q, ns_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [c_NUM_W-1:0]     num_q, num_d;
  logic [c_DCNT_W-1:0]    dcnt_q, dcnt_d;

  logic [CNT_W:0]         div_shift;
  logic [CNT_W-1:0]       div_trial, div_rem;
  logic                   div_ge;
  logic [c_NUM_W-1:0]     div_num;
  logic [FRE_W-1:0]       div_fre;
  logic                   div_ovf;

  logic                   out_ld, out_to, out_sat;
  logic [FRE_W-1:0]       out_fre, fre_q;
  logic [CNT_W-1:0]       out_nx, out_ns, nx_o_q, ns_o_q;
  logic                   valid_q, timeout_q, sat_q;

  // Synchronise clk_fx and detect its rising edge; the fixed latency applies
  // equally to the opening and closing edges, so it cancels out of Ns.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      fx_dly_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_fx};
      fx_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fx_rise = sync_q[SYNC_STAGES-1] & ~fx_dly_q;
  assign tmr_inc = tmr_q + CNT_W'(1);

  // One restoring-division step: shift in the next numerator bit, subtract Ns
  // when it fits. The remainder stays below Ns, so one extra bit suffices.
  assign div_shift = {rem_q, num_q[c_NUM_W-1]};
  assign div_ge    = (div_shift >= {1'b0, ns_q});
  assign div_trial = div_shift[CNT_W-1:0] - ns_q;
  assign div_rem   = div_ge ? div_trial : div_shift[CNT_W-1:0];
  assign div_num   = {num_q[c_NUM_W-2:0], div_ge};

  generate
    if (FRE_W < c_NUM_W) begin : g_sat
      assign div_ovf = |div_num[c_NUM_W-1:FRE_W];
      assign div_fre = div_ovf ? {FRE_W{1'b1}} : div_num[FRE_W-1:0];
    end else begin : g_nosat
      assign div_ovf = 1'b0;
      assign div_fre = FRE_W'(div_num);
    end
  endgenerate

  // Next-state, counter and result-load logic for the measurement sequence.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    nx_d    = nx_q;
    ns_d    = ns_q;
    rem_d   = rem_q;
    num_d   = num_q;
    dcnt_d  = dcnt_q;
    out_ld  = 1'b0;
    out_fre = '0;
    out_nx  = '0;
    out_ns  = '0;
    out_to  = 1'b0;
    out_sat = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (CONTINUOUS != 0) begin
          if (tmr_inc >= c_GAP) begin
            state_d = S_ARM;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end else if (start) begin
          state_d = S_ARM;
          tmr_d   = '0;
        end
      end
      S_ARM: begin
        if (fx_rise) begin
          state_d = S_OPEN;
          tmr_d   = '0;
          nx_d    = '0;
          ns_d    = '0;
        end else if (tmr_inc >= c_TIMEOUT) begin
          state_d = S_DONE;
          out_ld  = 1'b1;
          out_to  = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_OPEN: begin
        ns_d  = ns_q + CNT_W'(1);
        tmr_d = tmr_inc;
        if (fx_rise) nx_d = nx_q + CNT_W'(1);
        if (tmr_inc >= c_GATE) begin
          tmr_d   = '0;
          // A rise on the last gate cycle is itself the closing edge.
          state_d = fx_rise ? S_DIV : S_CLOSE;
        end
      end
      S_CLOSE: begin
        ns_d = ns_q + CNT_W'(1);
        if (fx_rise) begin
          nx_d    = nx_q + CNT_W'(1);
          tmr_d   = '0;
          state_d = S_DIV;
        end else if (tmr_inc >= c_TIMEOUT) begin
          tmr_d   = '0;
          state_d = S_DONE;
          out_ld  = 1'b1;
          out_to  = 1'b1;
          out_nx  = nx_d;
          out_ns  = ns_d;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_DIV: begin
        rem_d  = div_rem;
        num_d  = div_num;
        dcnt_d = dcnt_q + c_DCNT_W'(1);
        if (dcnt_q == c_DLAST) begin
          state_d = S_DONE;
          out_ld  = 1'b1;
          out_fre = div_fre;
          out_sat = div_ovf;
          out_nx  = nx_q;
          out_ns  = ns_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
    // Load the scaled numerator as the gate closes.
    if (state_d == S_DIV && state_q != S_DIV) begin
      num_d  = c_FREQ * {32'd0, nx_d};
      rem_d  = '0;
      dcnt_d = '0;
    end
  end

  // Sequencer state and measurement counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      nx_q    <= '0;
      ns_q    <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      nx_q    <= nx_d;
      ns_q    <= ns_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Result registers: loaded on entry to DONE so valid coincides with DONE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fre_q     <= '0;
      nx_o_q    <= '0;
      ns_o_q    <= '0;
      timeout_q <= 1'b0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= out_ld;
      if (out_ld) begin
        fre_q     <= out_fre;
        nx_o_q    <= out_nx;
        ns_o_q    <= out_ns;
        timeout_q <= out_to;
        sat_q     <= out_sat;
      end
    end
  end

  assign fre     = fre_q;
  assign nx      = nx_o_q;
  assign ns      = ns_o_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign sat     = sat_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cymometer_equal_precision.sv
`default_nettype none
// ============================================================================
// Module   : tb_cymometer_equal_precision
// Brief    : Scoreboard bench for the equal-precision frequency meter. DUT A is
//            single-shot (32-bit result), DUT B is free-running (16-bit result).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cymometer_equal_precision;

  typedef struct {
    logic [31:0] fre;
    logic [31:0] nx;
    logic [31:0] ns;
    logic        to;
    logic        sat;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n, fx_a, fx_b, start_a, start_b;
  logic [31:0] fre_a, nx_a, ns_a, nx_b, ns_b;
  logic [15:0] fre_b;
  logic        valid_a, busy_a, to_a, sat_a, valid_b, busy_b, to_b, sat_b;

  int   n_pass = 0, n_tot = 0, cyc = 0;
  int   per_a = 0, per_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cymometer_equal_precision #(
    .CLK_FREQ_HZ(50_000_000), .GATE_CYCLES(1000), .GAP_CYCLES(1000),
    .TIMEOUT_CYCLES(5000), .CNT_W(32), .FRE_W(32), .SYNC_STAGES(2), .CONTINUOUS(0)
  ) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a_n), .clk_fx(fx_a), .start(start_a),
    .fre(fre_a), .nx(nx_a), .ns(ns_a), .valid(valid_a), .busy(busy_a),
    .timeout(to_a), .sat(sat_a)
  );

  cymometer_equal_precision #(
    .CLK_FREQ_HZ(50_000_000), .GATE_CYCLES(1000), .GAP_CYCLES(1000),
    .TIMEOUT_CYCLES(5000), .CNT_W(32), .FRE_W(16), .SYNC_STAGES(2), .CONTINUOUS(1)
  ) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .clk_fx(fx_b), .start(start_b),
    .fre(fre_b), .nx(nx_b), .ns(ns_b), .valid(valid_b), .busy(busy_b),
    .timeout(to_b), .sat(sat_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else n_pass++;
  endtask

  // Synchronous fx generators: one rise every per_x sys_clk cycles; 0 holds low.
  initial begin
    int ph = 0;
    fx_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (per_a <= 0) begin fx_a = 1'b0; ph = 0; end
      else begin ph = (ph + 1) % per_a; fx_a = (ph < per_a / 2); end
    end
  end

  initial begin
    int ph = 0;
    fx_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (per_b <= 0) begin fx_b = 1'b0; ph = 0; end
      else begin ph = (ph + 1) % per_b; fx_b = (ph < per_b / 2); end
    end
  end

  // Monitor A: pops an expectation per valid strobe; latency measured from busy rise.
  initial begin
    logic prev_v = 1'b0, prev_b = 1'b0;
    int   arm_cyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_a && !prev_b) arm_cyc = cyc;
      if (valid_a) begin
        if (prev_v) chk("a_valid_one_cycle", 1, 0);
        else if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_fre", fre_a, e.fre);
          chk("a_nx", nx_a, e.nx);
          chk("a_ns", ns_a, e.ns);
          chk("a_timeout", to_a, e.to);
          chk("a_sat", sat_a, e.sat);
          if (e.lat >= 0) chk("a_latency", cyc - arm_cyc, e.lat);
        end
      end
      prev_v = valid_a;
      prev_b = busy_a;
    end
  end

  // Monitor B: same for the free-running 16-bit instance.
  initial begin
    logic prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_b) begin
        if (prev_v) chk("b_valid_one_cycle", 1, 0);
        else if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_fre", {16'd0, fre_b}, e.fre);
          chk("b_nx", nx_b, e.nx);
          chk("b_ns", ns_b, e.ns);
          chk("b_timeout", to_b, e.to);
          chk("b_sat", sat_b, e.sat);
        end
      end
      prev_v = valid_b;
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (busy_a && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk({name, "_wait_bound"}, 1, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_a(input int per, input logic [31:0] f, input logic [31:0] x,
                       input logic [31:0] s, input logic t, input int lat, input string name);
    exp_t e;
    per_a = per;
    repeat (20) @(posedge clk);
    e.fre = f; e.nx = x; e.ns = s; e.to = t; e.sat = 1'b0; e.lat = lat;
    qa.push_back(e);
    pulse_start_a();
    wait_idle_a(name);
  endtask

  task automatic chk_zero_a(input string pfx);
    chk({pfx, "_fre"}, fre_a, 0);
    chk({pfx, "_nx"}, nx_a, 0);
    chk({pfx, "_ns"}, ns_a, 0);
    chk({pfx, "_valid"}, valid_a, 0);
    chk({pfx, "_busy"}, busy_a, 0);
    chk({pfx, "_timeout"}, to_a, 0);
    chk({pfx, "_sat"}, sat_a, 0);
  endtask

  task automatic wait_valid_b(input string name);
    int n = 0;
    @(negedge clk);
    while (!valid_b && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk({name, "_wait_bound"}, 1, 0);
  endtask

  initial begin
    exp_t e;
    int   c0, n;
    rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_zero_a("reset");
    @(posedge clk); #1 rst_a_n = 1'b1;

    // 1 MHz, 3-cycle period (floored), 25 MHz.
    run_a(50, 32'd1_000_000, 32'd20, 32'd1000, 1'b0, -1, "p50");
    run_a(3, 32'd16_666_666, 32'd334, 32'd1002, 1'b0, -1, "p3");
    run_a(2, 32'd25_000_000, 32'd500, 32'd1000, 1'b0, -1, "p2");

    // No fx edges: timeout exactly TIMEOUT_CYCLES after ARM entry.
    run_a(0, 32'd0, 32'd0, 32'd0, 1'b1, 5000, "timeout");

    // A second start while busy must not launch another measurement.
    per_a = 50;
    repeat (20) @(posedge clk);
    e.fre = 32'd1_000_000; e.nx = 32'd20; e.ns = 32'd1000; e.to = 1'b0; e.sat = 1'b0; e.lat = -1;
    qa.push_back(e);
    pulse_start_a();
    repeat (100) @(posedge clk);
    pulse_start_a();
    wait_idle_a("restart");
    repeat (3000) @(negedge clk);
    chk("restart_ignored_busy", busy_a, 0);

    // Reset while the gate is open: outputs clear, no strobe.
    pulse_start_a();
    repeat (300) @(posedge clk);
    #1 rst_a_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_a("mid_reset");
    @(posedge clk); #1 rst_a_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("mid_reset_idle_busy", busy_a, 0);
    run_a(50, 32'd1_000_000, 32'd20, 32'd1000, 1'b0, -1, "post_reset");
    chk("a_scoreboard_empty", qa.size(), 0);

    // Free-running 16-bit instance: saturation then an in-range result.
    per_b = 50;
    repeat (20) @(posedge clk);
    e.fre = 32'd65535; e.nx = 32'd20; e.ns = 32'd1000; e.to = 1'b0; e.sat = 1'b1; e.lat = -1;
    qb.push_back(e);
    e.fre = 32'd50_000; e.nx = 32'd1; e.ns = 32'd1000; e.to = 1'b0; e.sat = 1'b0; e.lat = -1;
    qb.push_back(e);
    @(posedge clk); #1 rst_b_n = 1'b1;
    c0 = cyc;
    n = 0;
    @(negedge clk);
    while (!busy_b && n < 5000) begin @(negedge clk); n++; end
    chk("b_first_gap", cyc - c0, 1000);
    wait_valid_b("b_sat_run");
    per_b = 1000;
    wait_valid_b("b_50k_run");
    repeat (3) @(negedge clk);
    rst_b_n = 1'b0;
    chk("b_scoreboard_empty", qb.size(), 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
